// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one binary-to-BCD converter among requesters
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_Binary,
  output logic [N_REQ-1:0]   o_Grant,
  output logic [N_REQ-1:0]   o_Done,
  output logic               o_Error,
  output logic [2:0]         o_Id,
  output logic [3:0]         o_Ones,
  output logic [3:0]         o_Tens,
  output logic [3:0]         o_Hundreds,
  output logic               o_Busy,
  output logic               o_Conv_Start,
  output logic [7:0]         o_Conv_Binary,
  input  logic               i_Conv_Done,
  input  logic [3:0]         i_Conv_Ones,
  input  logic [3:0]         i_Conv_Tens,
  input  logic [3:0]         i_Conv_Hundreds
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  logic [0:0]       r_state;
  logic [7:0]       r_cnt;
  logic [2:0]       r_last;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_error;
  logic [2:0]       r_id;
  logic [3:0]       r_ones;
  logic [3:0]       r_tens;
  logic [3:0]       r_hundreds;
  logic             r_busy;
  logic             r_start;
  logic [7:0]       r_bin;
  logic [2:0]       w_win;
  logic             w_any;
  logic [7:0]       w_bin;
  logic [N_REQ-1:0] w_own;
  // Round-robin pick: scan from the farthest candidate back so the nearest one after r_last wins
  always_comb begin
    int k;
    w_win = '0;
    w_any = 1'b0;
    k     = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = (int'(r_last) + i) % N_REQ;
      if (((i_Req >> k) & N_REQ'(1)) != '0) begin
        w_win = 3'(k);
        w_any = 1'b1;
      end
    end
  end
  // Operand of the winner and one-hot of the requester currently being served
  always_comb begin
    w_bin = 8'(i_Binary >> (8 * int'(w_win)));
    w_own = N_REQ'(1) << r_last;
  end
  // Arbitration, converter handshake and timeout supervision
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= 3'(N_REQ - 1);
      r_grant    <= '0;
      r_done     <= '0;
      r_error    <= 1'b0;
      r_id       <= '0;
      r_ones     <= '0;
      r_tens     <= '0;
      r_hundreds <= '0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_bin      <= '0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      r_error <= 1'b0;
      r_start <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_any) begin
          r_grant <= N_REQ'(1) << w_win;
          r_start <= 1'b1;
          r_busy  <= 1'b1;
          r_bin   <= w_bin;
          r_cnt   <= '0;
          r_last  <= w_win;
          r_state <= S_WAIT;
        end
      end else if (i_Conv_Done) begin
        r_ones     <= i_Conv_Ones;
        r_tens     <= i_Conv_Tens;
        r_hundreds <= i_Conv_Hundreds;
        r_id       <= r_last;
        r_done     <= w_own;
        r_busy     <= 1'b0;
        r_state    <= S_IDLE;
      end else if (r_cnt == 8'(TIMEOUT)) begin
        r_id    <= r_last;
        r_done  <= w_own;
        r_error <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= S_IDLE;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
  assign o_Grant       = r_grant;
  assign o_Done        = r_done;
  assign o_Error       = r_error;
  assign o_Id          = r_id;
  assign o_Ones        = r_ones;
  assign o_Tens        = r_tens;
  assign o_Hundreds    = r_hundreds;
  assign o_Busy        = r_busy;
  assign o_Conv_Start  = r_start;
  assign o_Conv_Binary = r_bin;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: transaction-level model plus directed scenarios for the converter arbiter
module tb_bcd_conv_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;
  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] bin = '0;
  logic           conv_done = 1'b0;
  logic [3:0]     cv_o = '0, cv_t = '0, cv_h = '0;
  logic [N-1:0]   o_grant, o_done;
  logic           o_error, o_busy, o_start;
  logic [2:0]     o_id;
  logic [3:0]     o_ones, o_tens, o_hund;
  logic [7:0]     o_cbin;
  int n_chk = 0, n_fail = 0, cyc = 0, start_cyc = 0;
  int conv_lat = 9, cd = 0;
  int e_grant = 0, e_done = 0, e_err = 0, e_id = 0, e_o = 0, e_t = 0, e_h = 0;
  int e_busy = 0, e_start = 0, e_bin = 0;
  int m_busy = 0, m_last = N - 1, m_owner = 0, m_age = 0;
  typedef struct {int id; int err; int h; int t; int o;} done_t;
  done_t dq[$];
  int    gq[$];
  int    nd;
  always #5 clk = ~clk;
  bcd_conv_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_Req(req), .i_Binary(bin),
    .o_Grant(o_grant), .o_Done(o_done), .o_Error(o_error), .o_Id(o_id),
    .o_Ones(o_ones), .o_Tens(o_tens), .o_Hundreds(o_hund), .o_Busy(o_busy),
    .o_Conv_Start(o_start), .o_Conv_Binary(o_cbin), .i_Conv_Done(conv_done),
    .i_Conv_Ones(cv_o), .i_Conv_Tens(cv_t), .i_Conv_Hundreds(cv_h));
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask
  // Transaction model: a requester is served for an elapsed time, ending on done or after TO+1 cycles
  task automatic model_step();
    int picked;
    if (!rst_n) begin
      e_grant = 0; e_done = 0; e_err = 0; e_id = 0; e_o = 0; e_t = 0; e_h = 0;
      e_busy = 0; e_start = 0; e_bin = 0; m_busy = 0; m_last = N - 1;
    end else begin
      e_grant = 0; e_start = 0; e_done = 0; e_err = 0;
      if (m_busy == 0) begin
        picked = 0;
        for (int off = 1; off <= N; off++)
          if (picked == 0 && ((req >> ((m_last + off) % N)) & 1) != 0) begin
            picked  = 1;
            m_owner = (m_last + off) % N;
          end
        if (picked != 0) begin
          m_last  = m_owner;
          e_grant = 1 << m_owner;
          e_start = 1;
          e_busy  = 1;
          e_bin   = int'(8'(bin >> (8 * m_owner)));
          m_busy  = 1;
          m_age   = 0;
        end
      end else begin
        m_age++;
        if (conv_done) begin
          e_h = e_bin / 100; e_t = (e_bin / 10) % 10; e_o = e_bin % 10;
          e_id = m_owner; e_done = 1 << m_owner; e_busy = 0; m_busy = 0;
        end else if (m_age == TO + 1) begin
          e_id = m_owner; e_done = 1 << m_owner; e_err = 1; e_busy = 0; m_busy = 0;
        end
      end
    end
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end
  // Converter stand-in: answers conv_lat cycles after start (0 = never), ignores our reset
  initial forever begin
    @(negedge clk);
    conv_done = 1'b0;
    if (o_start) cd = conv_lat;
    else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        conv_done = 1'b1;
        cv_h = 4'(o_cbin / 100);
        cv_t = 4'((o_cbin / 10) % 10);
        cv_o = 4'(o_cbin % 10);
      end
    end
  end
  // Per-cycle comparison against the model, plus event logging
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    chk("grant", int'(o_grant), e_grant);
    chk("done", int'(o_done), e_done);
    chk("error", int'(o_error), e_err);
    chk("id", int'(o_id), e_id);
    chk("ones", int'(o_ones), e_o);
    chk("tens", int'(o_tens), e_t);
    chk("hundreds", int'(o_hund), e_h);
    chk("busy", int'(o_busy), e_busy);
    chk("conv_start", int'(o_start), e_start);
    chk("conv_binary", int'(o_cbin), e_bin);
    if (o_start) start_cyc = cyc;
    if (o_grant != 0) gq.push_back($clog2(o_grant));
    if (o_done != 0) dq.push_back('{int'(o_id), int'(o_error), int'(o_hund), int'(o_tens), int'(o_ones)});
  end
  task automatic wait_done(input int lim);
    int seen = 0;
    for (int i = 0; i < lim && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (o_done != 0) seen = 1;
    end
    if (seen == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: no o_Done within %0d cycles", lim);
    end
  endtask
  task automatic request(input int r, input int k, input int v);
    @(negedge clk);
    bin[8*k +: 8] = 8'(v);
    req = N'(r);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_grant", int'(o_grant), 0);
    chk("async_rst_cbin", int'(o_cbin), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Fairness: all four hold requests
    @(negedge clk);
    bin = {8'd255, 8'd200, 8'd99, 8'd0};
    req = 4'b1111;
    for (int i = 0; i < 200 && gq.size() < 5; i++) @(negedge clk);
    req = '0;
    wait_done(40);
    chk("fair_ngrants", gq.size(), 5);
    if (gq.size() >= 5) begin
      chk("fair_g0", gq[0], 0); chk("fair_g1", gq[1], 1); chk("fair_g2", gq[2], 2);
      chk("fair_g3", gq[3], 3); chk("fair_g4", gq[4], 0);
    end
    chk("fair_ndone", dq.size(), 5);
    if (dq.size() >= 4) begin
      chk("fair_d0", dq[0].h * 100 + dq[0].t * 10 + dq[0].o, 0);
      chk("fair_d1", dq[1].h * 100 + dq[1].t * 10 + dq[1].o, 99);
      chk("fair_d2_h", dq[2].h, 2); chk("fair_d2_t", dq[2].t, 0); chk("fair_d2_o", dq[2].o, 0);
      chk("fair_d3_h", dq[3].h, 2); chk("fair_d3_t", dq[3].t, 5); chk("fair_d3_o", dq[3].o, 5);
    end
    // Single request from requester 2
    request(4'b0100, 2, 173);
    @(posedge clk);
    #1;
    chk("single_grant", int'(o_grant), 4'b0100);
    chk("single_cbin", int'(o_cbin), 173);
    @(negedge clk) req = '0;
    wait_done(40);
    chk("single_done", int'(o_done), 4'b0100);
    chk("single_h", int'(o_hund), 1); chk("single_t", int'(o_tens), 7); chk("single_o", int'(o_ones), 3);
    chk("single_id", int'(o_id), 2); chk("single_err", int'(o_error), 0);
    chk("single_latency", cyc - start_cyc, 10);
    // Timeout: converter silent
    conv_lat = 0;
    request(4'b0010, 1, 42);
    @(negedge clk) req = '0;
    wait_done(40);
    chk("to_done", int'(o_done), 4'b0010);
    chk("to_err", int'(o_error), 1);
    chk("to_delay", cyc - start_cyc, 16);
    chk("to_hold_h", int'(o_hund), 1); chk("to_hold_t", int'(o_tens), 7); chk("to_hold_o", int'(o_ones), 3);
    conv_lat = 9;
    request(4'b1000, 3, 58);
    @(posedge clk);
    #1;
    chk("after_to_grant", int'(o_grant), 4'b1000);
    @(negedge clk) req = '0;
    wait_done(40);
    chk("after_to_val", int'(o_hund) * 100 + int'(o_tens) * 10 + int'(o_ones), 58);
    // Done arrives in the very cycle the timeout would fire
    conv_lat = TO;
    request(4'b0001, 0, 128);
    @(negedge clk) req = '0;
    wait_done(40);
    chk("coll_err", int'(o_error), 0);
    chk("coll_delay", cyc - start_cyc, 16);
    chk("coll_h", int'(o_hund), 1); chk("coll_t", int'(o_tens), 2); chk("coll_o", int'(o_ones), 8);
    // Reset during WAIT; converter strobe lands afterwards in IDLE
    conv_lat = 9;
    request(4'b0010, 1, 77);
    @(negedge clk) req = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_digits", int'(o_hund) + int'(o_tens) + int'(o_ones), 0);
    chk("midrst_done", int'(o_done), 0);
    nd = dq.size();
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", dq.size(), nd);
    request(4'b0101, 0, 11);
    bin[23:16] = 8'd22;
    @(posedge clk);
    #1;
    chk("midrst_grant", int'(o_grant), 4'b0001);
    @(negedge clk) req = '0;
    wait_done(40);
    chk("midrst_val", int'(o_hund) * 100 + int'(o_tens) * 10 + int'(o_ones), 11);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
